// File: rtl/tl_pkg.sv
// Shared types and default phase durations for the traffic light controller.
package tl_pkg;

    // Controller phases; NIGHT is only reachable when TRAFFIC_NIGHT_BLINK_EN is defined.
    typedef enum logic [2:0] {
        StAllRed,
        StRedYellow,
        StGreen,
        StYellow,
        StWalk,
        StNight
    } tl_state_e;

    localparam int unsigned DefNDir       = 2;
    localparam int unsigned DefTRedYellow = 1;
    localparam int unsigned DefTGreen     = 4;
    localparam int unsigned DefTYellow    = 2;
    localparam int unsigned DefTAllRed    = 1;
    localparam int unsigned DefTWalk      = 3;
    localparam int unsigned DefTBlink     = 2;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Loadable phase down-counter; holds at zero and flags done while it reads zero.
module tl_phase_timer #(
    parameter int unsigned Width    = 3,
    parameter int unsigned ResetVal = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    output logic             done
);

    logic [Width-1:0] cnt_q;

    // Load on phase entry, otherwise count down and park at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= Width'(ResetVal);
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - Width'(1);
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Round-robin traffic light controller with pedestrian walk phase.
// Optional night blink mode is compiled in by defining TRAFFIC_NIGHT_BLINK_EN;
// without it the night input is ignored.
module traffic_light_ctrl
    import tl_pkg::*;
#(
    parameter int unsigned N_DIR       = DefNDir,
    parameter int unsigned T_REDYELLOW = DefTRedYellow,
    parameter int unsigned T_GREEN     = DefTGreen,
    parameter int unsigned T_YELLOW    = DefTYellow,
    parameter int unsigned T_ALLRED    = DefTAllRed,
    parameter int unsigned T_WALK      = DefTWalk,
    parameter int unsigned T_BLINK     = DefTBlink
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ped_req,
    input  logic             night,
    output logic [N_DIR-1:0] red,
    output logic [N_DIR-1:0] yellow,
    output logic [N_DIR-1:0] green,
    output logic             ped_walk,
    output logic             ped_ack
);

    localparam int unsigned DirW = $clog2(N_DIR);
    localparam int unsigned TMax = max2(max2(max2(T_REDYELLOW, T_GREEN),
                                             max2(T_YELLOW, T_ALLRED)),
                                        max2(T_WALK, T_BLINK));
    localparam int unsigned TimerW = $clog2(TMax) + 1;

    localparam logic [TimerW-1:0] LdRedYellow = TimerW'(T_REDYELLOW - 1);
    localparam logic [TimerW-1:0] LdGreen     = TimerW'(T_GREEN - 1);
    localparam logic [TimerW-1:0] LdYellow    = TimerW'(T_YELLOW - 1);
    localparam logic [TimerW-1:0] LdAllRed    = TimerW'(T_ALLRED - 1);
    localparam logic [TimerW-1:0] LdWalk      = TimerW'(T_WALK - 1);
`ifdef TRAFFIC_NIGHT_BLINK_EN
    localparam logic [TimerW-1:0] LdBlink     = TimerW'(T_BLINK - 1);
`else
    logic night_unused;
    assign night_unused = night;
`endif

    tl_state_e        state_q, state_d;
    logic [DirW-1:0]  dir_q, dir_d;
    logic             pending_q, pending_d;
    logic             blink_q, blink_d;
    logic             tmr_load;
    logic [TimerW-1:0] tmr_val;
    logic             tmr_done;

    logic [N_DIR-1:0] red_d, yellow_d, green_d;
    logic             walk_d, ack_d;

    tl_phase_timer #(
        .Width    (TimerW),
        .ResetVal (T_ALLRED - 1)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // Next phase, direction, pending request and timer reload.
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        blink_d   = blink_q;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        // A request on the expiring ALL_RED edge is folded in here so it is served at once.
        pending_d = pending_q | (ped_req & (state_q != StWalk));

        case (state_q)
            StAllRed: begin
                if (tmr_done) begin
`ifdef TRAFFIC_NIGHT_BLINK_EN
                    if (night) begin
                        state_d  = StNight;
                        blink_d  = 1'b1;
                        tmr_load = 1'b1;
                        tmr_val  = LdBlink;
                    end else
`endif
                    if (pending_d) begin
                        state_d   = StWalk;
                        pending_d = 1'b0;
                        tmr_load  = 1'b1;
                        tmr_val   = LdWalk;
                    end else begin
                        state_d  = StRedYellow;
                        tmr_load = 1'b1;
                        tmr_val  = LdRedYellow;
                    end
                end
            end
            StRedYellow: begin
                if (tmr_done) begin
                    state_d  = StGreen;
                    tmr_load = 1'b1;
                    tmr_val  = LdGreen;
                end
            end
            StGreen: begin
                if (tmr_done) begin
                    state_d  = StYellow;
                    tmr_load = 1'b1;
                    tmr_val  = LdYellow;
                end
            end
            StYellow: begin
                if (tmr_done) begin
                    state_d  = StAllRed;
                    dir_d    = (dir_q == DirW'(N_DIR - 1)) ? '0 : dir_q + DirW'(1);
                    tmr_load = 1'b1;
                    tmr_val  = LdAllRed;
                end
            end
            StWalk: begin
                if (tmr_done) begin
                    state_d  = StAllRed;
                    tmr_load = 1'b1;
                    tmr_val  = LdAllRed;
                end
            end
`ifdef TRAFFIC_NIGHT_BLINK_EN
            StNight: begin
                // Leaving night restarts service from direction 0 after a full clearance.
                if (!night) begin
                    state_d  = StAllRed;
                    dir_d    = '0;
                    blink_d  = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = LdAllRed;
                end else if (tmr_done) begin
                    blink_d  = ~blink_q;
                    tmr_load = 1'b1;
                    tmr_val  = LdBlink;
                end
            end
`endif
            default: begin
                state_d  = StAllRed;
                dir_d    = '0;
                blink_d  = 1'b0;
                tmr_load = 1'b1;
                tmr_val  = LdAllRed;
            end
        endcase
    end

    // Lamp pattern for the phase being entered, so lamps switch on the same edge as the state.
    always_comb begin
        red_d    = '1;
        yellow_d = '0;
        green_d  = '0;
        walk_d   = 1'b0;
        case (state_d)
            StRedYellow: begin
                yellow_d[dir_d] = 1'b1;
            end
            StGreen: begin
                red_d[dir_d]   = 1'b0;
                green_d[dir_d] = 1'b1;
            end
            StYellow: begin
                red_d[dir_d]    = 1'b0;
                yellow_d[dir_d] = 1'b1;
            end
            StWalk: begin
                walk_d = 1'b1;
            end
            StNight: begin
                red_d    = '0;
                yellow_d = {N_DIR{blink_d}};
            end
            default: ;
        endcase
        ack_d = (state_d == StWalk) && (state_q != StWalk);
    end

    // Controller state and registered lamp outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StAllRed;
            dir_q     <= '0;
            pending_q <= 1'b0;
            blink_q   <= 1'b0;
            red       <= '1;
            yellow    <= '0;
            green     <= '0;
            ped_walk  <= 1'b0;
            ped_ack   <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            pending_q <= pending_d;
            blink_q   <= blink_d;
            red       <= red_d;
            yellow    <= yellow_d;
            green     <= green_d;
            ped_walk  <= walk_d;
            ped_ack   <= ack_d;
        end
    end

endmodule

// File: doc/traffic_light_ctrl.md
TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

Interface
REQ-001 Parameter N_DIR, default 2: number of conflicting approach directions served round-robin (legal 2..8).
REQ-002 Parameter T_REDYELLOW, default 1: red+yellow phase length in cycles (>=1).
REQ-003 Parameter T_GREEN, default 4: green phase length in cycles (>=1).
REQ-004 Parameter T_YELLOW, default 2: yellow phase length in cycles (>=1).
REQ-005 Parameter T_ALLRED, default 1: all-red clearance length in cycles (>=1).
REQ-006 Parameter T_WALK, default 3: pedestrian walk phase length in cycles (>=1).
REQ-007 Parameter T_BLINK, default 2: night-blink half-period in cycles (>=1).
REQ-008 clk  input  1  single clock, all state updates on posedge.
REQ-009 rst_n  input  1  reset, asynchronous, active-low.
REQ-010 ped_req  input  1  pedestrian request, level, sampled each posedge.
REQ-011 night  input  1  night-mode request, level.
REQ-012 red  output  N_DIR  red lamp per direction.
REQ-013 yellow  output  N_DIR  yellow lamp per direction.
REQ-014 green  output  N_DIR  green lamp per direction.
REQ-015 ped_walk  output  1  pedestrian walk lamp.
REQ-016 ped_ack  output  1  one-cycle pulse on WALK entry.

Function
REQ-017 States SHALL be ALL_RED, RED_YELLOW, GREEN, YELLOW, WALK, NIGHT; phase timer SHALL load T_x-1 on entry and advance when it reads 0, so each state lasts exactly T_x cycles.
REQ-018 Transitions: RED_YELLOW->GREEN->YELLOW->ALL_RED; ALL_RED->WALK if pending, else RED_YELLOW; WALK->ALL_RED.
REQ-019 Active direction index SHALL increment (mod N_DIR, wrap N_DIR-1->0) on each YELLOW->ALL_RED exit, never elsewhere.
REQ-020 Lamps for active direction: RED_YELLOW red+yellow, GREEN green only, YELLOW yellow only; all other directions and ALL_RED/WALK show red only.
REQ-021 At most one bit of green SHALL ever be set; green and ped_walk SHALL never be high together.
REQ-022 ped_req high at any posedge outside WALK SHALL set pending; pending cleared on WALK entry; ped_req during WALK SHALL be ignored.
REQ-023 ped_ack SHALL be high exactly the first cycle of WALK; ped_walk high for all T_WALK cycles.
REQ-024 Pending set on the same edge ALL_RED expires SHALL be serviced in that transition (WALK entered).
REQ-025 Outputs SHALL be registered: lamps change on the same edge as the state change, no combinational input-to-output path.

Reset
REQ-026 rst_n low SHALL immediately force: state ALL_RED, direction 0, timer T_ALLRED-1, pending 0, red all ones, yellow/green 0, ped_walk 0, ped_ack 0, blink phase 0.
REQ-027 Reset asserted mid-phase SHALL abort the phase with no completion; first posedge after release starts a full T_ALLRED.

Configuration
REQ-028 Macro TRAFFIC_NIGHT_BLINK_EN: when defined, night high at ALL_RED expiry SHALL enter NIGHT (red/green/ped_walk 0, all yellow toggling every T_BLINK cycles starting on, pending held); night low in NIGHT SHALL exit to ALL_RED with fresh T_ALLRED and direction 0.
REQ-029 Without TRAFFIC_NIGHT_BLINK_EN, night port SHALL exist but be ignored and NIGHT unreachable.

Structure
REQ-030 Package tl_pkg SHALL hold the state enum and default duration constants.
REQ-031 Sub-module tl_phase_timer: loadable down-counter, width $clog2(max T)+1, outputs done at 0.

Verification (N_DIR=2, T_REDYELLOW=1, T_GREEN=4, T_YELLOW=2, T_ALLRED=1, T_WALK=3, T_BLINK=2)
REQ-032 Release reset, no requests -> 16-cycle period: dir0 red+yellow 1, green 4, yellow 2, all-red 1, then dir1 same; green one-hot.
REQ-033 ped_req one-cycle pulse during dir0 GREEN -> after following ALL_RED: ped_ack 1 cycle, ped_walk 3 cycles, all red, then ALL_RED 1, dir1 RED_YELLOW.
REQ-034 ped_req held high through WALK -> exactly one WALK, then normal dir1 service.
REQ-035 rst_n low 1 cycle in dir1 GREEN -> red=2'b11 immediately, restart at dir0 after 1 all-red cycle.
REQ-036 Macro defined, night high -> after current ALL_RED, yellow=2'b11 for 2 cycles, 2'b00 for 2, repeating; night low -> ALL_RED 1, dir0 RED_YELLOW.
REQ-037 Macro undefined, night high 40 cycles -> identical trace to REQ-032.
